uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 5, meaning wb_clk_i cycles per serial bit (>=2).
REQ-003 SHALL have port wb_clk_i  input  1  meaning sole clock; all state on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  meaning asynchronous active-high reset.
REQ-005 SHALL have port req_valid  input  NREQ  meaning requester i offers a byte.
REQ-006 SHALL have port req_data  input  8*NREQ  meaning byte of requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NREQ  meaning offered byte ends requester i's message.
REQ-008 SHALL have port req_ready  output  NREQ  meaning one-hot, one-cycle accept pulse.
REQ-009 SHALL have port ser_tx  output  1  meaning serial line, idle high.
REQ-010 SHALL have port busy  output  1  meaning a frame is in progress.
REQ-011 SHALL have port grant_valid  output  1  meaning a requester holds the line lock.
REQ-012 SHALL have port grant_id  output  3  meaning index of lock holder; zero-extended.

Function
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-014 In IDLE, unlocked: SHALL grant the first i with req_valid[i], searching round-robin from rr_ptr; none valid -> stay IDLE.
REQ-015 In IDLE, locked: SHALL consider only grant_id; other requesters wait even if valid.
REQ-016 Byte accepted in cycle T (req_valid[g]=1 in IDLE): req_ready[g]=1 in T only; data and last latched; grant_valid=1, grant_id=g from T+1.
REQ-017 Transfer: req_valid[i] & req_ready[i]; req_ready SHALL never assert to a non-valid or non-granted requester.
REQ-018 START: ser_tx=0 for CLKS_PER_BIT cycles from T+1.
REQ-019 DATA: 8 bits LSB first, each CLKS_PER_BIT cycles.
REQ-020 STOP: ser_tx=1 for CLKS_PER_BIT cycles, then IDLE; frame = 10*CLKS_PER_BIT cycles.
REQ-021 IDLE SHALL last >=1 cycle between frames; back-to-back bytes start 10*CLKS_PER_BIT+1 cycles apart.
REQ-022 busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.
REQ-023 Leaving STOP with latched last=1: clear grant_valid, set rr_ptr=(grant_id+1) mod NREQ; with last=0: keep lock.
REQ-024 Locked owner dropping req_valid: lock held indefinitely, ser_tx idle high; no timeout.
REQ-025 req_valid/req_data changes outside the accept cycle SHALL NOT affect the frame in flight.
REQ-026 Bit counter 3 bits, wraps 7->STOP; divider counter width $clog2(CLKS_PER_BIT), reload 0 at terminal count.
REQ-027 rr_ptr wraps NREQ-1 -> 0.

Reset
REQ-028 wb_rst_i=1 SHALL immediately force ser_tx=1, req_ready=0, busy=0, grant_valid=0, grant_id=0, rr_ptr=0, state IDLE, counters 0.
REQ-029 Reset mid-frame SHALL discard the partial byte and lock; no resumption after release.
REQ-030 First accept SHALL occur no earlier than the first rising edge after wb_rst_i deasserts.

Structure
REQ-031 Shared package SHALL hold the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT.
REQ-032 Serializer (START/DATA/STOP, divider, bit counter) SHALL be sub-module uart_tx_serializer with load/data/busy/ser_tx; arbitration and lock stay in the top.

Verification (NREQ=4, CLKS_PER_BIT=5)
REQ-033 Req 2 sends 0x41 last=1 -> req_ready[2] one cycle; ser_tx 0,1,0,0,0,0,0,1,0,1 at 5 cycles/bit; grant cleared after 50 cycles; rr_ptr=3.
REQ-034 Req 0 and 3 valid, rr_ptr=0 -> req 0 first; after its last byte, req 3 granted; next contest with both valid -> req 0.
REQ-035 Req 1 sends "HI\n" (last on 0x0A) while req 0 valid -> req 0 blocked until 0x0A stop bit ends; req 1 bytes 51 cycles apart.
REQ-036 Req 1 locked, drops valid 200 cycles, req 2 valid -> ser_tx high, req_ready[2]=0 throughout; req 1 resumes on return.
REQ-037 wb_rst_i pulsed during DATA bit 4 -> ser_tx=1 same time step, busy=0, grant_valid=0; next accept frames correctly.
REQ-038 Bench tbuart decodes every frame of REQ-033..REQ-036 to the sent bytes, no framing errors.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the multi-requester UART transmitter: serializer state
// encoding, default bit timing and the round-robin index helper.
package uart_tx_arbiter_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 5;
  localparam int ID_W                 = 3;
  localparam int MAX_REQ              = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // (base + offs) mod n, valid while base < n and offs < n (n <= MAX_REQ).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input logic [ID_W-1:0] offs,
                                               input int unsigned     n);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + {1'b0, offs};
    if (sum >= (ID_W+1)'(n)) begin
      sum = sum - (ID_W+1)'(n);
    end
    return sum[ID_W-1:0];
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: start bit, eight data bits LSB first, stop bit, each
// CLKS_PER_BIT clocks long. done pulses in the final stop-bit cycle.
module uart_tx_serializer
  import uart_tx_arbiter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ser_tx
);

  localparam int              DIV_W    = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ser_tx_q, ser_tx_d;
  logic             tick;

  assign tick   = (div_q == DIV_LAST);
  assign busy   = (state_q != IDLE);
  assign ser_tx = ser_tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      ser_tx_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      ser_tx_q <= ser_tx_d;
    end
  end

  // ser_tx is registered from the next-state value so the line never glitches.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    ser_tx_d = ser_tx_q;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        ser_tx_d = 1'b1;
        if (load) begin
          state_d  = START;
          div_d    = '0;
          bit_d    = '0;
          shreg_d  = data;
          ser_tx_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          div_d    = '0;
          state_d  = DATA;
          ser_tx_d = shreg_q[0];
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          div_d = '0;
          if (bit_q == 3'd7) begin
            state_d  = STOP;
            bit_d    = '0;
            ser_tx_d = 1'b1;
          end else begin
            bit_d    = bit_q + 3'd1;
            shreg_d  = {1'b0, shreg_q[7:1]};
            ser_tx_d = shreg_q[1];
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STOP: begin
        ser_tx_d = 1'b1;
        if (tick) begin
          div_d   = '0;
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        ser_tx_d = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters; a
// grant locks the line to its owner until a byte flagged last has been sent.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              ser_tx,
  output logic              busy,
  output logic              grant_valid,
  output logic [2:0]        grant_id
);

  if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
    $error("uart_tx_arbiter: NREQ must be in 2..8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_arbiter: CLKS_PER_BIT must be >= 2");
  end

  logic [MAX_REQ-1:0] valid_ext;
  logic [MAX_REQ-1:0] last_ext;
  logic [7:0]         byte_ext [MAX_REQ];

  logic            grant_valid_q, grant_valid_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            last_q, last_d;

  logic            sel_valid;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] cand;
  logic            ser_busy;
  logic            ser_done;

  // Pad requester inputs to eight lanes so a 3-bit id can index them directly.
  for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_ext
    if (gi < NREQ) begin : g_used
      assign valid_ext[gi] = req_valid[gi];
      assign last_ext[gi]  = req_last[gi];
      assign byte_ext[gi]  = req_data[8*gi +: 8];
    end else begin : g_pad
      assign valid_ext[gi] = 1'b0;
      assign last_ext[gi]  = 1'b0;
      assign byte_ext[gi]  = 8'h00;
    end
  end

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = grant_id_q;
    cand      = '0;
    if (!wb_rst_i && !ser_busy) begin
      if (grant_valid_q) begin
        sel_valid = valid_ext[grant_id_q];
      end else begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          cand = wrap_add(rr_ptr_q, ID_W'(k), NREQ);
          if (valid_ext[cand]) begin
            sel_valid = 1'b1;
            sel_id    = cand;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign req_ready[gi] = sel_valid && (sel_id == ID_W'(gi));
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    last_d        = last_q;
    if (sel_valid) begin
      grant_valid_d = 1'b1;
      grant_id_d    = sel_id;
      last_d        = last_ext[sel_id];
    end else if (ser_done && last_q) begin
      grant_valid_d = 1'b0;
      rr_ptr_d      = wrap_add(grant_id_q, ID_W'(1), NREQ);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      last_q        <= 1'b0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      last_q        <= last_d;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serializer (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .load   (sel_valid),
    .data   (byte_ext[sel_id]),
    .busy   (ser_busy),
    .done   (ser_done),
    .ser_tx (ser_tx)
  );

  assign busy        = ser_busy;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed requester scenarios, an accept
// monitor checking grant order and a serial decoder checking every frame.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int CPB  = 5;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i = 1'b1;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              ser_tx;
  logic              busy;
  logic              grant_valid;
  logic [2:0]        grant_id;

  always #5 wb_clk_i = ~wb_clk_i;

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .ser_tx      (ser_tx),
    .busy        (busy),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Requester byte queues ({last, byte}) and the scoreboard queues.
  logic [8:0]      rq [NREQ][$];
  logic [NREQ-1:0] en;
  logic [NREQ-1:0] acc;
  int              exp_id_q[$];
  logic [7:0]      exp_line_q[$];

  int acc_count = 0;
  int acc_cyc [64];
  int mon_id;

  logic            s_ser, s_busy, s_gv;
  logic [2:0]      s_gid;
  logic [NREQ-1:0] s_ready;

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      logic [8:0] e;
      e = 9'h000;
      if (rq[i].size() > 0) e = rq[i][0];
      req_valid[i]        = en[i] && (rq[i].size() > 0);
      req_data[8*i +: 8]  = e[7:0];
      req_last[i]         = e[8];
    end
  endtask

  task automatic tick();
    @(negedge wb_clk_i);
    s_ser   = ser_tx;
    s_busy  = busy;
    s_gv    = grant_valid;
    s_gid   = grant_id;
    s_ready = req_ready;
    acc     = req_ready & req_valid;
    @(posedge wb_clk_i);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    drive();
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_count < n && k < budget) begin
      tick();
      k++;
    end
    check(name, acc_count, n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (k < budget) begin
      tick();
      k++;
      if (!s_busy) break;
    end
    check(name, int'(s_busy), 0);
  endtask

  // Accept monitor: every grant must match the predicted requester order.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i && req_ready != '0) begin
      check("ready_onehot_valid",
            int'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 1);
      mon_id = 0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_id = i;
      $display("accept: requester %0d byte 0x%02h at cycle %0d",
               mon_id, req_data[8*mon_id +: 8], cyc);
      if (exp_id_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL accept_unexpected: got requester %0d expected no accept", mon_id);
      end else begin
        check("accept_id", mon_id, exp_id_q.pop_front());
      end
      if (acc_count < 64) acc_cyc[acc_count] = cyc;
      acc_count++;
    end
  end

  // Serial decoder: detects a start bit and samples each bit mid-cell.
  logic       dec_busy = 1'b0;
  int         dec_cnt  = 0;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      dec_busy = 1'b0;
      dec_cnt  = 0;
    end else if (!dec_busy) begin
      if (ser_tx == 1'b0) begin
        dec_busy = 1'b1;
        dec_cnt  = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt == CPB / 2) begin
        check("frame_start_bit", int'(ser_tx), 0);
      end else if (dec_cnt >= CPB + CPB / 2 && dec_cnt <= 8 * CPB + CPB / 2 &&
                   (dec_cnt - CPB / 2) % CPB == 0) begin
        dec_byte = {ser_tx, dec_byte[7:1]};
      end else if (dec_cnt == 9 * CPB + CPB / 2) begin
        check("frame_stop_bit", int'(ser_tx), 1);
        $display("frame: decoded 0x%02h", dec_byte);
        if (exp_line_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_unexpected: got 0x%02h expected no frame", dec_byte);
        end else begin
          check("frame_byte", int'(dec_byte), int'(exp_line_q.pop_front()));
        end
        dec_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0;
    int         rel_cyc;
    int         bad;
    int         idx;
    logic       eb;
    logic [7:0] b41;

    en        = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    wb_rst_i  = 1'b1;
    b41       = 8'h41;

    // A: requester 2 offers 0x41 already during reset.
    rq[2].push_back({1'b1, 8'h41});
    exp_id_q.push_back(2);
    exp_line_q.push_back(8'h41);
    en[2] = 1'b1;
    drive();
    repeat (3) begin
      tick();
      check("rst_ser_tx", int'(s_ser), 1);
      check("rst_busy", int'(s_busy), 0);
      check("rst_grant_valid", int'(s_gv), 0);
      check("rst_grant_id", int'(s_gid), 0);
      check("rst_req_ready", int'(s_ready), 0);
    end
    wb_rst_i = 1'b0;
    rel_cyc  = cyc;
    wait_acc(1, 10, "A_accept");
    check("A_first_accept_cycle", acc_cyc[0], rel_cyc);
    bad = 0;
    for (int n = 1; n <= 10 * CPB + 1; n++) begin
      tick();
      if (n <= 10 * CPB) begin
        idx = (n - 1) / CPB;
        if (idx == 0)      eb = 1'b0;
        else if (idx == 9) eb = 1'b1;
        else               eb = b41[idx-1];
        if (s_ser !== eb || !s_busy || !s_gv || s_gid != 3'd2 || s_ready != '0) bad++;
        if (n % CPB == 3) check($sformatf("A_bit_cell%0d", idx), int'(s_ser), int'(eb));
      end else begin
        check("A_busy_after_frame", int'(s_busy), 0);
        check("A_grant_cleared", int'(s_gv), 0);
      end
    end
    check("A_frame_cycles", bad, 0);

    // B: rr_ptr is 3, so requester 3 beats 0, then rotation alternates.
    rq[0].push_back({1'b1, 8'h30});
    rq[3].push_back({1'b1, 8'h33});
    rq[3].push_back({1'b1, 8'h34});
    exp_id_q.push_back(3); exp_line_q.push_back(8'h33);
    exp_id_q.push_back(0); exp_line_q.push_back(8'h30);
    exp_id_q.push_back(3); exp_line_q.push_back(8'h34);
    en = 4'b1001;
    drive();
    wait_acc(4, 200, "B_accepts");
    wait_idle(100, "B_idle");

    // C: requester 0 locks for two bytes, 3 waits; next contest goes to 0.
    rq[0].push_back({1'b0, 8'h50});
    rq[0].push_back({1'b1, 8'h51});
    rq[0].push_back({1'b1, 8'h52});
    rq[3].push_back({1'b1, 8'h60});
    rq[3].push_back({1'b1, 8'h61});
    exp_id_q.push_back(0); exp_line_q.push_back(8'h50);
    exp_id_q.push_back(0); exp_line_q.push_back(8'h51);
    exp_id_q.push_back(3); exp_line_q.push_back(8'h60);
    exp_id_q.push_back(0); exp_line_q.push_back(8'h52);
    exp_id_q.push_back(3); exp_line_q.push_back(8'h61);
    drive();
    wait_acc(9, 400, "C_accepts");
    check("C_lock_gap", acc_cyc[5] - acc_cyc[4], 10 * CPB + 1);
    wait_idle(100, "C_idle");

    // D: requester 1 sends "HI\n" while requester 0 is waiting.
    en = 4'b0010;
    rq[1].push_back({1'b0, 8'h48});
    rq[1].push_back({1'b0, 8'h49});
    rq[1].push_back({1'b1, 8'h0A});
    rq[0].push_back({1'b1, 8'h70});
    exp_id_q.push_back(1); exp_line_q.push_back(8'h48);
    exp_id_q.push_back(1); exp_line_q.push_back(8'h49);
    exp_id_q.push_back(1); exp_line_q.push_back(8'h0A);
    exp_id_q.push_back(0); exp_line_q.push_back(8'h70);
    drive();
    wait_acc(10, 20, "D_first_accept");
    en[0] = 1'b1;
    drive();
    wait_acc(13, 300, "D_accepts");
    check("D_gap_H_I", acc_cyc[10] - acc_cyc[9], 10 * CPB + 1);
    check("D_gap_I_LF", acc_cyc[11] - acc_cyc[10], 10 * CPB + 1);
    check("D_release_gap", acc_cyc[12] - acc_cyc[11], 10 * CPB + 1);
    wait_idle(100, "D_idle");

    // E: locked owner 1 goes silent for 200 cycles while 2 is valid.
    en = 4'b0010;
    rq[1].push_back({1'b0, 8'h11});
    rq[1].push_back({1'b1, 8'h12});
    rq[2].push_back({1'b1, 8'h22});
    exp_id_q.push_back(1); exp_line_q.push_back(8'h11);
    exp_id_q.push_back(1); exp_line_q.push_back(8'h12);
    exp_id_q.push_back(2); exp_line_q.push_back(8'h22);
    drive();
    wait_acc(14, 20, "E_first_accept");
    en = 4'b0100;
    drive();
    wait_idle(100, "E_idle");
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (s_ser !== 1'b1 || s_busy || !s_gv || s_gid != 3'd1 || s_ready != '0) bad++;
    end
    check("E_line_held_idle", bad, 0);
    check("E_no_accept", acc_count, 14);
    en = 4'b0110;
    drive();
    wait_acc(16, 200, "E_resume_accepts");
    wait_idle(100, "E_idle2");

    // F: reset in the middle of data bit 4 of 0x45, then a clean frame.
    en = 4'b0001;
    rq[0].push_back({1'b1, 8'h45});
    exp_id_q.push_back(0);
    drive();
    wait_acc(17, 20, "F_accept");
    t0 = acc_cyc[16];
    for (int n = 1; n <= 5 + 4 * CPB + 2; n++) tick();
    check("F_bit4_low", int'(s_ser), 0);
    check("F_busy_before_rst", int'(s_busy), 1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("F_rst_ser_tx", int'(ser_tx), 1);
    check("F_rst_busy", int'(busy), 0);
    check("F_rst_grant_valid", int'(grant_valid), 0);
    check("F_rst_req_ready", int'(req_ready), 0);
    tick();
    tick();
    wb_rst_i = 1'b0;
    en = 4'b0010;
    rq[1].push_back({1'b1, 8'h3C});
    exp_id_q.push_back(1);
    exp_line_q.push_back(8'h3C);
    drive();
    wait_acc(18, 20, "F_after_rst_accept");
    check("F_accept_delay", acc_cyc[17] - t0 > 0 ? 1 : 0, 1);
    wait_idle(100, "F_idle");
    check("F_grant_released", int'(s_gv), 0);

    repeat (4) tick();
    check("sb_accepts_drained", exp_id_q.size(), 0);
    check("sb_frames_drained", exp_line_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
